// File: rtl/dense_layer_engine_pkg.sv
// Shared types and elaboration helpers for the dense layer engine.
package dense_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so single-entry address ports keep a bit.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 1;
        for (int k = 1; k < 31; k++) begin
            if ((32'd1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    function automatic bit accWidthOk(input int accW, input int xW, input int wW, input int nIn);
        return (accW >= xW + wW + clog2(nIn + 1) + 1) && (accW <= 64);
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int outW);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (outW - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        else if (v < lo) return lo;
        else return v;
    endfunction

endpackage

// File: rtl/dense_layer_engine_mac_pipe.sv
// Product register, bias-loaded accumulator and scale/saturate result register.
// Build option DENSE_RELU_EN clamps negative scaled results to zero.
module mac_pipe import dense_pkg::*; #(
    parameter int X_W       = 8,
    parameter int W_W       = 16,
    parameter int FRAC_BITS = 12,
    parameter int ACC_W     = 36,
    parameter int OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [X_W-1:0]          xData,
    input  logic signed [W_W-1:0]   wData,
    input  logic                    loadBias,
    input  logic                    prodEn,
    input  logic                    accEn,
    input  logic                    resLoad,
    output logic signed [OUT_W-1:0] result
);
    localparam int P_W = X_W + 1 + W_W;

    logic signed [P_W-1:0]   prod_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] accNext_s;
    logic signed [ACC_W-1:0] accShift_s;
    logic signed [63:0]      satIn_s;
    logic signed [63:0]      satOut_s;

    // Next accumulator value: a bias load replaces any stale sum.
    always_comb begin
        accNext_s = acc_r;
        if (loadBias) begin
            accNext_s = ACC_W'(wData);
        end else if (accEn) begin
            accNext_s = acc_r + ACC_W'(prod_r);
        end else begin
            accNext_s = acc_r;
        end
    end

    // Scale by arithmetic shift (floor), optional ReLU, then saturate.
    always_comb begin
        accShift_s = accNext_s >>> FRAC_BITS;
        satIn_s    = 64'(accShift_s);
`ifdef DENSE_RELU_EN
        if (satIn_s < 64'sd0) begin
            satIn_s = 64'sd0;
        end else begin
            satIn_s = 64'(accShift_s);
        end
`endif
        satOut_s = sat_signed(satIn_s, OUT_W);
    end

    // Pipeline registers; x is zero-extended so the multiply stays signed.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r <= '0;
            acc_r  <= '0;
            result <= '0;
        end else begin
            if (prodEn) prod_r <= P_W'($signed({1'b0, xData})) * P_W'(wData);
            acc_r <= accNext_s;
            if (resLoad) result <= satOut_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: sequencing FSM and RAM address generation.
// Build option DENSE_RELU_EN enables ReLU on results (see mac_pipe).
module dense_layer_engine import dense_pkg::*; #(
    parameter int N_IN      = 784,
    parameter int N_OUT     = 10,
    parameter int X_W       = 8,
    parameter int W_W       = 16,
    parameter int FRAC_BITS = 12,
    parameter int ACC_W     = 36,
    parameter int OUT_W     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [clog2(N_IN)-1:0]                x_addr,
    input  logic [X_W-1:0]                        x_data,
    output logic [clog2(N_OUT*(N_IN+1))-1:0]      w_addr,
    input  logic signed [W_W-1:0]                 w_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [OUT_W-1:0]               out_data,
    output logic [clog2(N_OUT)-1:0]               out_idx
);
    localparam int XA_W  = clog2(N_IN);
    localparam int WA_W  = clog2(N_OUT * (N_IN + 1));
    localparam int IDX_W = clog2(N_OUT);

    if (!accWidthOk(ACC_W, X_W, W_W, N_IN)) begin : gAccCheck
        $error("dense_layer_engine: ACC_W too narrow for X_W, W_W and N_IN");
    end

    state_t           state_r;
    logic [IDX_W-1:0] jCnt_r;
    logic [WA_W-1:0]  base_r;
    logic             drain_r;
    logic             biasD1_r;
    logic             macD1_r;
    logic             macD2_r;
    logic             resLoad_s;

    assign resLoad_s = (state_r == S_DRAIN) && drain_r;

    // Layer sequencing; x_addr doubles as the input index i.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            jCnt_r    <= '0;
            base_r    <= '0;
            drain_r   <= 1'b0;
            biasD1_r  <= 1'b0;
            macD1_r   <= 1'b0;
            macD2_r   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            x_addr    <= '0;
            w_addr    <= '0;
        end else begin
            done     <= 1'b0;
            biasD1_r <= (state_r == S_BIAS);
            macD1_r  <= (state_r == S_MAC);
            macD2_r  <= macD1_r;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_BIAS;
                        jCnt_r  <= '0;
                        base_r  <= '0;
                        w_addr  <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_BIAS: begin
                    state_r <= S_MAC;
                    x_addr  <= '0;
                    w_addr  <= base_r + WA_W'(1);
                end
                S_MAC: begin
                    if (x_addr == XA_W'(N_IN - 1)) begin
                        state_r <= S_DRAIN;
                        drain_r <= 1'b0;
                    end else begin
                        x_addr <= x_addr + XA_W'(1);
                        w_addr <= w_addr + WA_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_r) begin
                        state_r   <= S_OUT;
                        out_valid <= 1'b1;
                        out_idx   <= jCnt_r;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (jCnt_r == IDX_W'(N_OUT - 1)) begin
                            state_r <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_r <= S_BIAS;
                            jCnt_r  <= jCnt_r + IDX_W'(1);
                            base_r  <= base_r + WA_W'(N_IN + 1);
                            w_addr  <= base_r + WA_W'(N_IN + 1);
                        end
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    mac_pipe #(
        .X_W(X_W), .W_W(W_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) uMac (
        .clk(clk),
        .rst(rst),
        .xData(x_data),
        .wData(w_data),
        .loadBias(biasD1_r),
        .prodEn(macD1_r),
        .accEn(macD2_r),
        .resLoad(resLoad_s),
        .result(out_data)
    );

endmodule

// File: tb/tb_dense_layer_engine.sv
// Self-checking bench: table vectors, stall/reset/restart sequences and random passes.
module tb_dense_layer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic rst, startA, readyA, busyA, doneA, validA;
    logic [1:0] xAddrA;
    logic [3:0] wAddrA;
    logic [7:0] xDataA;
    logic [15:0] wDataA;
    logic signed [15:0] outDataA;
    logic [0:0] idxA;
    logic [7:0] xMemA [4];
    logic [15:0] wMemA [10];

    logic startB, readyB, busyB, doneB, validB;
    logic [0:0] xAddrB;
    logic [2:0] wAddrB;
    logic [7:0] xDataB;
    logic [15:0] wDataB;
    logic signed [15:0] outDataB;
    logic [1:0] idxB;
    logic [7:0] xMemB [2];
    logic [15:0] wMemB [8];

    dense_layer_engine #(.N_IN(4), .N_OUT(2), .FRAC_BITS(0)) dutA (
        .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
        .x_addr(xAddrA), .x_data(xDataA), .w_addr(wAddrA), .w_data(wDataA),
        .out_valid(validA), .out_ready(readyA), .out_data(outDataA), .out_idx(idxA)
    );

    dense_layer_engine #(.N_IN(1), .N_OUT(3), .FRAC_BITS(12)) dutB (
        .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
        .x_addr(xAddrB), .x_data(xDataB), .w_addr(wAddrB), .w_data(wDataB),
        .out_valid(validB), .out_ready(readyB), .out_data(outDataB), .out_idx(idxB)
    );

    always @(posedge clk) begin
        xDataA <= xMemA[xAddrA];
        wDataA <= wMemA[wAddrA];
        xDataB <= xMemB[xAddrB];
        wDataB <= wMemB[wAddrB];
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: floor-shift, optional ReLU, clamp to 16-bit signed.
    function automatic int scaleRef(input longint s, input int f);
        longint v;
        v = s >>> f;
`ifdef DENSE_RELU_EN
        if (v < 0) v = 0;
`endif
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return int'(v);
    endfunction

    function automatic int modelA(input int j);
        longint s;
        s = longint'($signed(wMemA[j*5]));
        for (int i = 0; i < 4; i++) s += longint'(xMemA[i]) * longint'($signed(wMemA[j*5+1+i]));
        return scaleRef(s, 0);
    endfunction

    function automatic int modelB(input int j);
        longint s;
        s = longint'($signed(wMemB[j*2])) + longint'(xMemB[0]) * longint'($signed(wMemB[j*2+1]));
        return scaleRef(s, 12);
    endfunction

    task automatic checkResetA(input string tag);
        check({tag, "_busy"}, busyA, 0);
        check({tag, "_done"}, doneA, 0);
        check({tag, "_valid"}, validA, 0);
        check({tag, "_data"}, outDataA, 0);
        check({tag, "_idx"}, idxA, 0);
        check({tag, "_xaddr"}, xAddrA, 0);
        check({tag, "_waddr"}, wAddrA, 0);
    endtask

    // One pass on dutA; cycle k is counted from the cycle start was sampled.
    task automatic runA(input int stall, input int rstAt, input bit midStart, input int e0, input int e1);
        int nRes, nDone, doneCyc, firstValid, stallLeft, stray;
        logic signed [15:0] holdD;
        logic [0:0] holdI;
        logic prevBusy;
        nRes = 0; nDone = 0; doneCyc = -1; firstValid = -1; stallLeft = stall;
        holdD = '0; holdI = '0; prevBusy = 1'b0;
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        check("busy_after_start", busyA, 1);
        for (int k = 1; k < 100; k++) begin
            if (k > 1) @(negedge clk);
            if (rstAt != 0 && k == rstAt) rst = 1'b1;
            if (rstAt != 0 && k == rstAt + 1) begin
                checkResetA("midrst");
                rst = 1'b0;
                stray = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (doneA || validA || busyA) stray++;
                end
                check("quiet_after_rst", stray, 0);
                return;
            end
            if (midStart) startA = (k == 5 || k == 12);
            if (validA) begin
                if (firstValid < 0) firstValid = k;
                if (stallLeft > 0 && nRes == 0) begin
                    if (stallLeft == stall) begin
                        holdD = outDataA; holdI = idxA;
                    end else begin
                        check("stall_data_stable", outDataA, holdD);
                        check("stall_idx_stable", idxA, holdI);
                    end
                    readyA = 1'b0;
                    stallLeft--;
                end else begin
                    readyA = 1'b1;
                    check("res_idx", idxA, nRes);
                    check("res_data", outDataA, (nRes == 0) ? e0 : e1);
                    nRes++;
                end
            end else begin
                readyA = 1'b1;
            end
            if (doneA) begin
                nDone++;
                if (doneCyc < 0) begin
                    doneCyc = k;
                    check("busy_low_at_done", busyA, 0);
                    check("busy_high_before_done", prevBusy, 1);
                end
            end
            prevBusy = busyA;
            if (doneCyc > 0 && k >= doneCyc + 3) break;
        end
        startA = 1'b0;
        readyA = 1'b1;
        check("result_count", nRes, 2);
        check("done_pulses", nDone, 1);
        check("done_cycle", doneCyc, 17 + stall);
        check("first_valid_cycle", firstValid, 8);
    endtask

    task automatic runB(input int ex0, input int ex1, input int ex2);
        int nRes, nDone;
        int ex [3];
        ex[0] = ex0; ex[1] = ex1; ex[2] = ex2;
        nRes = 0; nDone = 0;
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        for (int k = 0; k < 60 && nDone == 0; k++) begin
            @(negedge clk);
            if (validB && nRes < 3) begin
                check("b_idx", idxB, nRes);
                check("b_data", outDataB, ex[nRes]);
                nRes++;
            end
            if (doneB) nDone++;
        end
        check("b_result_count", nRes, 3);
        check("b_done_seen", nDone, 1);
    endtask

    typedef struct {
        logic [3:0][7:0]  x;
        logic [9:0][15:0] w;
        int e0;
        int e1;
    } vecA_t;

    vecA_t tbl [3];

    task automatic loadA(input vecA_t v);
        for (int i = 0; i < 4; i++) xMemA[i] = v.x[i];
        for (int i = 0; i < 10; i++) wMemA[i] = v.w[i];
    endtask

    initial begin
        tbl[0].x = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].w = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000,
                    16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005};
        tbl[0].e0 = 15;
`ifdef DENSE_RELU_EN
        tbl[0].e1 = 0;
`else
        tbl[0].e1 = -1;
`endif
        tbl[1].x = {4{8'd255}};
        tbl[1].w = {10{16'h7FFF}};
        tbl[1].e0 = 32767;
        tbl[1].e1 = 32767;
        tbl[2].x = {4{8'd255}};
        tbl[2].w = {10{16'h8000}};
`ifdef DENSE_RELU_EN
        tbl[2].e0 = 0;
        tbl[2].e1 = 0;
`else
        tbl[2].e0 = -32768;
        tbl[2].e1 = -32768;
`endif

        rst = 1'b1; startA = 1'b0; readyA = 1'b1; startB = 1'b0; readyB = 1'b1;
        for (int i = 0; i < 2; i++) xMemB[i] = 8'd0;
        for (int i = 0; i < 8; i++) wMemB[i] = 16'd0;
        repeat (3) @(negedge clk);
        checkResetA("reset");
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            loadA(tbl[t]);
            runA(0, 0, 1'b0, tbl[t].e0, tbl[t].e1);
        end

        loadA(tbl[0]);
        runA(7, 0, 1'b0, tbl[0].e0, tbl[0].e1);
        runA(0, 11, 1'b0, tbl[0].e0, tbl[0].e1);
        runA(0, 0, 1'b0, tbl[0].e0, tbl[0].e1);
        runA(0, 0, 1'b1, tbl[0].e0, tbl[0].e1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) xMemA[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 10; i++) begin
                if (r % 2 == 0) wMemA[i] = 16'($urandom_range(0, 1023)) - 16'd512;
                else wMemA[i] = 16'($urandom());
            end
            runA(0, 0, 1'b0, modelA(0), modelA(1));
        end

        xMemB[0] = 8'd3;
        wMemB[0] = 16'h0000; wMemB[1] = 16'h0800;
        wMemB[2] = 16'h0000; wMemB[3] = 16'hF800;
        wMemB[4] = 16'h1234; wMemB[5] = 16'h7000;
`ifdef DENSE_RELU_EN
        runB(1, 0, modelB(2));
`else
        runB(1, -2, modelB(2));
`endif
        for (int r = 0; r < 4; r++) begin
            xMemB[0] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 6; i++) wMemB[i] = 16'($urandom());
            runB(modelB(0), modelB(1), modelB(2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
